// File: rtl/fifo_lab_reader.sv
// Read-side controller for the fifo_lab async FIFO: issues rd_en bursts, captures
// buff_out one cycle later into a 4-entry skid buffer and streams it out on valid/ready.
//
// state | meaning
// IDLE  | no reads; waiting for threshold or flush with data
// READ  | issuing rd_en whenever availability and skid credit allow
// DRAIN | no new reads; waiting for in-flight reads to land
module fifo_lab_reader #(
   parameter int DATA_W       = 8,
   parameter int CNT_W        = 7,
   parameter int BURST_THRESH = 4
) (
   input  logic              clk_r,
   input  logic              rst,
   input  logic [CNT_W-1:0]  fifo_counter,
   input  logic [DATA_W-1:0] buff_out,
   output logic              rd_en,
   input  logic              flush,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [15:0]       words_read
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t            state, state_nx;
   logic              rd_en_nx;
   logic              cap;
   logic [DATA_W-1:0] mem [4];
   logic [1:0]        wptr, rptr;
   logic [2:0]        count, occ_after;
   logic [CNT_W-1:0]  avail;
   logic              pop, start, credit_ok, can_issue;

   assign out_valid = (count != 3'd0);
   assign out_data  = mem[rptr];
   assign busy      = (state != IDLE) || out_valid;
   assign pop       = out_valid & out_ready;

   // fifo_counter lags our own strobe by a cycle, so discount the read in flight
   assign avail     = fifo_counter - CNT_W'(rd_en);
   assign occ_after = count + {2'b00, cap} - {2'b00, pop};
   assign credit_ok = (occ_after + {2'b00, rd_en}) < 3'd4;
   assign can_issue = credit_ok && (avail != '0);
   assign start     = (fifo_counter >= CNT_W'(BURST_THRESH)) ||
                      (flush && (fifo_counter != '0));

   always_comb begin
      state_nx = state;
      rd_en_nx = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = READ;
               rd_en_nx = can_issue;
            end
         end
         READ: begin
            rd_en_nx = can_issue;
            if (avail == CNT_W'(rd_en_nx)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (!rd_en && !cap) begin
               if (start) begin
                  state_nx = READ;
                  rd_en_nx = can_issue;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_r or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rd_en <= 1'b0;
         cap   <= 1'b0;
      end else begin
         state <= state_nx;
         rd_en <= rd_en_nx;
         cap   <= rd_en;
      end
   end

   // skid buffer: capture and pop in the same cycle both take effect
   always_ff @(posedge clk_r or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
         wptr       <= 2'd0;
         rptr       <= 2'd0;
         count      <= 3'd0;
         words_read <= 16'd0;
      end else begin
         if (cap) begin
            mem[wptr] <= buff_out;
            wptr      <= wptr + 2'd1;
         end
         if (pop) begin
            rptr       <= rptr + 2'd1;
            words_read <= words_read + 16'd1;
         end
         count <= occ_after;
      end
   end

endmodule

// File: tb/tb_fifo_lab_reader.sv
// Bench for fifo_lab_reader: queue-based FIFO model, order scoreboard and
// per-cycle checks of credit, stability and transfer count.
module tb_fifo_lab_reader;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 7;

   logic              clk_r = 1'b0;
   logic              rst = 1'b1;
   logic [CNT_W-1:0]  fifo_counter = '0;
   logic [DATA_W-1:0] buff_out = '0;
   logic              rd_en;
   logic              flush = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              busy;
   logic [15:0]       words_read;

   int n_pass = 0;
   int n_total = 0;

   logic [7:0] fq[$];
   logic [7:0] wr_pend[$];
   logic [7:0] exp_q[$];
   logic [7:0] out_log[$];
   int         rd_cnt = 0;
   bit         underflow = 1'b0;
   int         held = 0;
   int         xfer_cnt = 0;
   bit         stall_q = 1'b0;
   logic [7:0] stall_data = '0;

   always #5 clk_r = ~clk_r;

   fifo_lab_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_THRESH(4)) dut (
      .clk_r(clk_r), .rst(rst), .fifo_counter(fifo_counter), .buff_out(buff_out),
      .rd_en(rd_en), .flush(flush), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .words_read(words_read)
   );

   task automatic check(string name, int act, int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk_r);
         #1;
      end
   endtask

   task automatic push_word(logic [7:0] b);
      wr_pend.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic wait_idle(string name, bit rnd);
      int k;
      k = 0;
      while ((busy || fq.size() != 0 || wr_pend.size() != 0) && k < 500) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         cyc(1);
         k++;
      end
      check({name, "_timeout"}, int'(k < 500), 1);
   endtask

   // FIFO model: pop on rd_en, data and new count visible the next cycle
   always @(posedge clk_r) begin
      if (rst) begin
         fq.delete();
         wr_pend.delete();
         fifo_counter <= '0;
      end else begin
         if (rd_en) begin
            rd_cnt++;
            if (fq.size() == 0) underflow = 1'b1;
            else buff_out <= fq.pop_front();
         end
         while (wr_pend.size() > 0) fq.push_back(wr_pend.pop_front());
         fifo_counter <= CNT_W'(fq.size());
      end
   end

   always @(negedge clk_r) begin : cmp
      logic [7:0] e;
      if (rst) begin
         exp_q.delete();
         held = 0;
         xfer_cnt = 0;
         stall_q = 1'b0;
      end else begin
         check("words_read", int'(words_read), xfer_cnt % 65536);
         check("underflow", int'(underflow), 0);
         check("credit", int'((held + int'(rd_en)) <= 4), 1);
         if (stall_q) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), int'(stall_data));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", int'(out_data), -1);
            end else begin
               e = exp_q.pop_front();
               check("out_data", int'(out_data), int'(e));
            end
            out_log.push_back(out_data);
            xfer_cnt++;
            held--;
         end
         if (rd_en) held++;
         stall_q    = out_valid && !out_ready;
         stall_data = out_data;
      end
   end

   initial begin
      int rd0, x0, pushed;
      logic [15:0] w0;

      // reset
      cyc(3);
      check("rst_rd_en", int'(rd_en), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_data", int'(out_data), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_words_read", int'(words_read), 0);
      rst = 1'b0;
      cyc(2);

      // threshold
      out_ready = 1'b1;
      rd0 = rd_cnt;
      push_word(8'h01); push_word(8'h02); push_word(8'h03);
      cyc(20);
      check("thresh_no_read", rd_cnt - rd0, 0);
      push_word(8'h04);
      wait_idle("thresh", 1'b0);
      check("thresh_reads", rd_cnt - rd0, 4);
      check("thresh_words_read", int'(words_read), 4);
      check("thresh_busy", int'(busy), 0);

      // flush
      rd0 = rd_cnt;
      push_word(8'hAB); push_word(8'hAF);
      flush = 1'b1;
      wait_idle("flush", 1'b0);
      cyc(5);
      check("flush_reads", rd_cnt - rd0, 2);
      check("flush_first", int'(out_log[4]), 8'hAB);
      check("flush_second", int'(out_log[5]), 8'hAF);
      flush = 1'b0;

      // backpressure
      out_ready = 1'b0;
      rd0 = rd_cnt;
      for (int i = 0; i < 10; i++) push_word(8'(8'h10 + i));
      cyc(15);
      check("bp_reads", rd_cnt - rd0, 4);
      check("bp_counter", int'(fifo_counter), 6);
      check("bp_valid", int'(out_valid), 1);
      check("bp_head", int'(out_data), 8'h10);
      cyc(3);
      check("bp_head_stable", int'(out_data), 8'h10);
      out_ready = 1'b1;
      x0 = xfer_cnt;
      cyc(10);
      check("bp_rate", xfer_cnt - x0, 10);
      wait_idle("bp", 1'b0);

      // random backpressure with random data
      w0 = words_read;
      pushed = 0;
      for (int c = 0; c < 2000 && pushed < 64; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            push_word(8'($urandom_range(0, 255)));
            pushed++;
         end
         cyc(1);
      end
      flush = 1'b1;
      wait_idle("rand", 1'b1);
      check("rand_words", int'(16'(words_read - w0)), 64);

      // reset mid-burst
      out_ready = 1'b0;
      flush = 1'b0;
      for (int i = 0; i < 10; i++) push_word(8'(8'h40 + i));
      cyc(3);
      check("mid_rd_en_pre", int'(rd_en), 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rd_en", int'(rd_en), 0);
      check("mid_out_valid", int'(out_valid), 0);
      check("mid_words_read", int'(words_read), 0);
      cyc(2);
      rst = 1'b0;
      cyc(2);

      // wrap of words_read
      out_ready = 1'b1;
      flush = 1'b1;
      pushed = 0;
      for (int c = 0; c < 70000 && pushed < 65539; c++) begin
         if (fq.size() < 64) begin
            push_word(8'(pushed));
            pushed++;
         end
         cyc(1);
      end
      wait_idle("wrap", 1'b0);
      check("wrap_xfers", xfer_cnt, 65539);
      check("wrap_words_read", int'(words_read), 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fifo_lab_reader.md
# fifo_lab_reader

Read-side controller for the `fifo_lab` asynchronous FIFO, running entirely in the read clock domain. It watches the FIFO's read-side occupancy, issues `rd_en` in bursts, captures `buff_out` with the FIFO's one-cycle read latency, and presents the words downstream on a valid/ready stream through a 4-entry skid buffer. It is the consumer counterpart to the write-side stimulus that drives `clk_w`/`wr_en`/`buff_in`.

## Interface
- `DATA_W`, 8, data width; matches `buff_out`.
- `CNT_W`, 7, width of `fifo_counter`.
- `BURST_THRESH`, 4, minimum FIFO occupancy that starts a burst (1..64).
- `clk_r`  in  1  read clock; the block's only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fifo_counter`  in  CNT_W  FIFO occupancy in the read domain.
- `buff_out`  in  DATA_W  FIFO read data, valid the cycle after `rd_en`.
- `rd_en`  out  1  FIFO read strobe, registered.
- `flush`  in  1  level; start a burst whenever FIFO is non-empty, ignoring threshold.
- `out_data`  out  DATA_W  head of skid buffer.
- `out_valid`  out  1  skid buffer non-empty.
- `out_ready`  in  1  downstream accept; transfer when `out_valid & out_ready`.
- `busy`  out  1  state != IDLE or skid buffer non-empty.
- `words_read`  out  16  count of completed downstream transfers, wraps.

## Operation
- FIFO contract: `rd_en` high in cycle t → FIFO pops at end of t; `buff_out` valid in t+1; `fifo_counter` shows the decrement from t+1. Block never relies on `buff_out` in any other cycle.
- Effective availability: `avail = fifo_counter - rd_en` (the in-cycle read is not yet reflected). `rd_en` is never asserted for the next cycle when `avail == 0` → no underflow reads.
- Outstanding: reads issued but not yet captured (0..2). Capture of `buff_out` into the skid buffer at the end of the cycle after each `rd_en`.
- Credit rule: `rd_en` asserted for the next cycle only if (skid occupancy + outstanding, both as they stand after this edge) < 4. Guarantees no capture is ever dropped.
- Skid buffer: 4-entry FIFO, first-in first-out; capture and pop in the same cycle both take effect.
- FSM:
  - IDLE: `rd_en`=0. → READ when `fifo_counter >= BURST_THRESH`, or `flush` and `fifo_counter != 0`.
  - READ: assert `rd_en` each cycle permitted by availability and credit. → DRAIN when `avail` would reach 0 after this edge's read.
  - DRAIN: `rd_en`=0; wait until outstanding == 0. → READ if `fifo_counter >= BURST_THRESH` or (`flush` and non-empty); else → IDLE.
- Credit stall in READ (buffer full) holds READ with `rd_en`=0; it does not exit the burst.
- `words_read`: +1 per downstream transfer; 16'hFFFF → 16'h0000.
- `out_data` is held stable while `out_valid & !out_ready`.

## Timing
- Reset (async assert, released synchronously to `clk_r` by the system): state IDLE, `rd_en`=0, `out_valid`=0, `out_data`=0, `busy`=0, `words_read`=0, outstanding 0, skid emptied. Reset mid-burst discards captured and in-flight words; FIFO-side data popped before reset is lost by design.
- Start latency: threshold met in cycle t → `rd_en` high in t+1 → first `out_valid` in t+3 (capture end of t+2).
- Throughput: with `out_ready` held high, one word per cycle sustained once started.
- Backpressure: `out_ready` low → at most 4 words held; `rd_en` stops so that (occupancy + outstanding) never exceeds 4.
- `flush` is sampled each cycle; dropping it mid-burst does not abort the burst.

## Test plan
- Reset: hold `rst`=1, toggle `clk_r` → all outputs 0; assert `rst` mid-burst → `rd_en` and `out_valid` drop to 0 immediately, `words_read`=0.
- Threshold: FIFO model loaded with 3 words (`fifo_counter`=3), `flush`=0 → `rd_en` stays 0 for 20 cycles; write a 4th → exactly 4 `rd_en` pulses, 4 words out in order, `words_read`=4, back to IDLE, `busy`=0.
- Flush: FIFO holds 8'hAB, 8'hAF, `flush`=1 → two reads, `out_data` 8'hAB then 8'hAF, no third `rd_en` while `fifo_counter`=0.
- Backpressure: 10 words queued, `out_ready`=0 → exactly 4 reads issued, `fifo_counter`=6, `out_data` stable; release `out_ready` → remaining 6 delivered in order at 1/cycle, no loss or duplication.
- Random `out_ready` (50%) with 64 random words → output sequence equals input sequence, no `rd_en` while `avail`=0, `words_read`=64.
- Wrap: preload `words_read` scenario of 65 536 + 3 transfers → `words_read`=3.
